i2c_cfg_sequencer: RTL and testbench

I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

---
 rtl/i2c_cfg_sequencer_pkg.sv | 26 ++
 rtl/i2c_cfg_delay.sv | 28 ++
 rtl/i2c_cfg_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared types and constants for the I2C configuration table sequencer.
// Holds the FSM state encoding and the reserved register codes used as table markers.
package i2c_cfg_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_CHECK,
        S_DELAY,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [15:0] END_MARKER   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARKER = 16'hFFFE;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i2c_cfg_delay.sv
// Loadable down-counter used for table delay entries.
// Counts down to zero and parks there; zero is high whenever the count is exhausted.
module i2c_cfg_delay #(
    parameter int unsigned CW = 18
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a register table and replays each {reg, data} entry as an I2C write through an
// external driver, with per-entry retries, delay entries, a busy-rise timeout and an end marker.
module i2c_cfg_sequencer
    import i2c_cfg_sequencer_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR  = 8'h78,
    parameter int unsigned TBL_AW    = 6,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned DLY_UNIT  = 800,
    parameter int unsigned BUSY_TMO  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              cfg_start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic              drv_start_en,
    output logic              drv_wr_rd_flag,
    output logic [7:0]        drv_dev_addr,
    output logic [15:0]       drv_register,
    output logic [7:0]        drv_data_byte,
    input  logic              drv_busy,
    input  logic              drv_err,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_fail,
    output logic [TBL_AW-1:0] fail_index
);

    localparam int unsigned CW = cnt_width(255 * DLY_UNIT);
    localparam int unsigned TW = cnt_width(BUSY_TMO);
    localparam int unsigned RW = cnt_width(MAX_RETRY);

    state_t            state_q, state_d;
    logic [TBL_AW-1:0] idx_q, idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [15:0]       reg_d;
    logic [7:0]        data_d;
    logic              dly_load, dly_zero, advance, accept;
    logic [CW-1:0]     dly_val;

    assign tbl_addr       = idx_q;
    assign drv_wr_rd_flag = 1'b0;
    assign drv_dev_addr   = DEV_ADDR;
    assign dly_val        = CW'(32'(tbl_data[7:0]) * DLY_UNIT);

    i2c_cfg_delay #(.CW(CW)) u_delay (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (dly_val),
        .zero     (dly_zero)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        tmo_d        = '0;
        err_d        = err_q;
        reg_d        = drv_register;
        data_d       = drv_data_byte;
        dly_load     = 1'b0;
        advance      = 1'b0;
        accept       = 1'b0;
        drv_start_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start && !drv_busy) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (tbl_data[23:8] == END_MARKER) begin
                    state_d = S_DONE;
                end else if (tbl_data[23:8] == DELAY_MARKER) begin
                    dly_load = 1'b1;
                    state_d  = S_DELAY;
                end else begin
                    reg_d   = tbl_data[23:8];
                    data_d  = tbl_data[7:0];
                    state_d = S_ISSUE;
                end
            end
            // Request stays up until the driver shows busy; tmo counts request cycles.
            S_ISSUE, S_WAIT_HI: begin
                drv_start_en = 1'b1;
                if (drv_busy) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TW'(BUSY_TMO - 1)) begin
                    state_d = S_FAIL;
                end else begin
                    tmo_d   = tmo_q + TW'(1);
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_LO: begin
                if (!drv_busy) begin
                    err_d   = drv_err;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!err_q) begin
                    advance = 1'b1;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_DELAY: begin
                if (dly_zero) advance = 1'b1;
            end
            S_DONE, S_FAIL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The last table slot finishes the walk instead of wrapping to index 0.
        if (advance) begin
            retry_d = '0;
            if (idx_q == '1) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + TBL_AW'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            retry_q       <= '0;
            tmo_q         <= '0;
            err_q         <= 1'b0;
            drv_register  <= '0;
            drv_data_byte <= '0;
            cfg_busy      <= 1'b0;
            cfg_done      <= 1'b0;
            cfg_fail      <= 1'b0;
            fail_index    <= '0;
        end else begin
            idx_q         <= idx_d;
            retry_q       <= retry_d;
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            drv_register  <= reg_d;
            drv_data_byte <= data_d;
            if (accept) begin
                cfg_busy <= 1'b1;
                cfg_done <= 1'b0;
                cfg_fail <= 1'b0;
            end
            if (state_d == S_DONE) begin
                cfg_busy <= 1'b0;
                cfg_done <= 1'b1;
            end
            if (state_d == S_FAIL) begin
                cfg_busy   <= 1'b0;
                cfg_fail   <= 1'b1;
                fail_index <= idx_q;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Self-checking bench for i2c_cfg_sequencer: table ROM and I2C driver models, a list-walk
// reference model, directed vectors, multi-cycle corner sequences and randomized tables.
module tb_i2c_cfg_sequencer;

    localparam int AW        = 6;
    localparam int DEPTH     = 64;
    localparam int MAX_RETRY = 3;
    localparam int DLY_UNIT  = 800;
    localparam int BUSY_TMO  = 8;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [AW-1:0] tbl_addr;
    logic [23:0]   tbl_data;
    logic          drv_start_en, drv_wr_rd_flag;
    logic [7:0]    drv_dev_addr;
    logic [15:0]   drv_register;
    logic [7:0]    drv_data_byte;
    logic          drv_busy, drv_err;
    logic          cfg_busy, cfg_done, cfg_fail;
    logic [AW-1:0] fail_index;

    i2c_cfg_sequencer #(
        .DEV_ADDR (8'h78), .TBL_AW (AW), .MAX_RETRY (MAX_RETRY),
        .DLY_UNIT (DLY_UNIT), .BUSY_TMO (BUSY_TMO)
    ) dut (
        .clk_i (clk_i), .rst_n (rst_n), .cfg_start (cfg_start),
        .tbl_addr (tbl_addr), .tbl_data (tbl_data),
        .drv_start_en (drv_start_en), .drv_wr_rd_flag (drv_wr_rd_flag),
        .drv_dev_addr (drv_dev_addr), .drv_register (drv_register),
        .drv_data_byte (drv_data_byte), .drv_busy (drv_busy), .drv_err (drv_err),
        .cfg_busy (cfg_busy), .cfg_done (cfg_done), .cfg_fail (cfg_fail),
        .fail_index (fail_index)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Table ROM: data valid one cycle after the address changes.
    logic [23:0] tbl [DEPTH];
    always @(posedge clk_i) tbl_data <= tbl[tbl_addr];

    // Driver model state and logs.
    bit          drv_mute = 1'b0;
    int          drv_hold_dur = 0;
    logic        nack_seq [256];
    int          att_n = 0;
    int          hold_bad = 0;
    logic [23:0] att_log [$];
    int          start_cyc [$];
    int          fall_cyc [$];

    initial begin
        logic [23:0] cap;
        int          lat, dur;
        drv_busy = 1'b0;
        drv_err  = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (drv_start_en && !drv_busy && !drv_mute) begin
                start_cyc.push_back(cyc);
                lat = $urandom_range(0, 3);
                dur = (drv_hold_dur > 0) ? drv_hold_dur : $urandom_range(1, 4);
                repeat (lat) begin @(posedge clk_i); #1; end
                drv_busy = 1'b1;
                cap = {drv_register, drv_data_byte};
                att_log.push_back(cap);
                repeat (dur) begin @(posedge clk_i); #1; end
                if ({drv_register, drv_data_byte} !== cap) hold_bad++;
                drv_err = (att_n < 256) ? nack_seq[att_n] : 1'b0;
                att_n++;
                drv_busy = 1'b0;
                fall_cyc.push_back(cyc);
            end
        end
    end

    // Reference model: walk the table as a list, consuming one ACK/NACK per attempt.
    logic [23:0] exp_q [$];
    logic        m_fail;
    logic [5:0]  m_fidx;

    task automatic model_run();
        int k = 0;
        bit ok;
        exp_q.delete();
        m_fail = 1'b0;
        m_fidx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl[i][23:8] == 16'hFFFF) break;
            if (tbl[i][23:8] == 16'hFFFE) continue;
            ok = 1'b0;
            for (int a = 0; a <= MAX_RETRY; a++) begin
                exp_q.push_back(tbl[i]);
                k++;
                if (!nack_seq[k-1]) begin ok = 1'b1; break; end
            end
            if (!ok) begin m_fail = 1'b1; m_fidx = 6'(i); break; end
        end
    endtask

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_table();
        for (int j = 0; j < DEPTH; j++) tbl[j] = 24'hFFFF00;
        for (int k = 0; k < 256; k++) nack_seq[k] = 1'b0;
    endtask

    task automatic prep();
        att_log.delete();
        start_cyc.delete();
        fall_cyc.delete();
        att_n    = 0;
        hold_bad = 0;
        model_run();
    endtask

    task automatic pulse_start();
        @(posedge clk_i); #1 cfg_start = 1'b1;
        @(posedge clk_i); #1 cfg_start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int waited = 0;
        while (!(cfg_done || cfg_fail) && waited < 30000) begin
            @(negedge clk_i);
            waited++;
        end
        n_tests++;
        if (waited >= 30000) begin
            n_fail++;
            $display("FAIL %s finish: no done/fail after %0d cycles, expected completion", name, waited);
        end
    endtask

    task automatic compare_model(input string name);
        logic [23:0] mm_act, mm_exp;
        check({name, " done"}, 64'(cfg_done), 64'(!m_fail));
        check({name, " fail"}, 64'(cfg_fail), 64'(m_fail));
        if (m_fail) check({name, " fail_index"}, 64'(fail_index), 64'(m_fidx));
        check({name, " cfg_busy"}, 64'(cfg_busy), 64'(0));
        check({name, " attempts"}, 64'(att_log.size()), 64'(exp_q.size()));
        mm_act = '0;
        mm_exp = '0;
        for (int i = 0; i < att_log.size() && i < exp_q.size(); i++) begin
            if (att_log[i] !== exp_q[i] && mm_act == mm_exp) begin
                mm_act = att_log[i];
                mm_exp = exp_q[i];
            end
        end
        check({name, " seq"}, 64'(mm_act), 64'(mm_exp));
        check({name, " hold"}, 64'(hold_bad), 64'(0));
    endtask

    task automatic run_cfg(input string name);
        prep();
        pulse_start();
        wait_end(name);
        compare_model(name);
        repeat (2) @(negedge clk_i);
    endtask

    typedef struct packed {
        logic [4:0][23:0] ent;
        logic [7:0]       nack;
        logic             exp_fail;
        logic [5:0]       exp_fidx;
        logic [7:0]       exp_att;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int gap, hi, waited;

        // ent listed last-to-first; nack bit k refers to global attempt k.
        vecs[0] = '{{24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'h310303, 24'h300882}, 8'h00, 1'b0, 6'd0, 8'd2};
        vecs[1] = '{{24'hFFFF00, 24'hFFFF00, 24'h300033, 24'h200022, 24'h100011}, 8'h06, 1'b0, 6'd0, 8'd5};
        vecs[2] = '{{24'hFFFF00, 24'hFFFF00, 24'h300033, 24'h200022, 24'h100011}, 8'h3C, 1'b1, 6'd2, 8'd6};
        vecs[3] = '{{24'hFFFF00, 24'hFFFF00, 24'h789ABC, 24'hFFFE00, 24'h123456}, 8'h00, 1'b0, 6'd0, 8'd2};
        vecs[4] = '{{24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00}, 8'h00, 1'b0, 6'd0, 8'd0};
        vecs[5] = '{{24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hAAAA01}, 8'h0F, 1'b1, 6'd0, 8'd4};
        vecs[6] = '{{24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hBBBB02, 24'hAAAA01}, 8'h07, 1'b0, 6'd0, 8'd5};

        rst_n     = 1'b0;
        cfg_start = 1'b0;
        clear_table();
        repeat (3) @(negedge clk_i);
        check("reset outputs", 64'({drv_start_en, tbl_addr, drv_register, drv_data_byte,
                                    cfg_busy, cfg_done, cfg_fail, fail_index}), 64'(0));
        check("dev addr/wr flag", 64'({drv_wr_rd_flag, drv_dev_addr}), 64'(9'h078));
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);

        for (int v = 0; v < 7; v++) begin
            clear_table();
            for (int j = 0; j < 5; j++) tbl[j] = vecs[v].ent[j];
            for (int k = 0; k < 8; k++) nack_seq[k] = vecs[v].nack[k];
            run_cfg($sformatf("vec%0d", v));
            check($sformatf("vec%0d fail const", v), 64'(cfg_fail), 64'(vecs[v].exp_fail));
            check($sformatf("vec%0d attempts const", v), 64'(att_log.size()), 64'(vecs[v].exp_att));
            if (vecs[v].exp_fail) check($sformatf("vec%0d fidx const", v), 64'(fail_index), 64'(vecs[v].exp_fidx));
        end

        // Two-unit delay entry between writes; a restart request mid-delay must be ignored.
        clear_table();
        tbl[0] = 24'h111101;
        tbl[1] = 24'hFFFE02;
        tbl[2] = 24'h222202;
        prep();
        pulse_start();
        repeat (300) @(negedge clk_i);
        pulse_start();
        wait_end("delay");
        compare_model("delay");
        gap = (start_cyc.size() > 1 && fall_cyc.size() > 0) ? start_cyc[1] - fall_cyc[0] : -1;
        n_tests++;
        if (gap < 1600 || gap > 1620) begin
            n_fail++;
            $display("FAIL delay gap: got %0d cycles, expected 1600..1620", gap);
        end
        repeat (2) @(negedge clk_i);

        // Driver never answers: request held BUSY_TMO cycles, then abort.
        clear_table();
        tbl[0] = 24'h555555;
        prep();
        drv_mute = 1'b1;
        pulse_start();
        hi = 0;
        waited = 0;
        while (!cfg_fail && waited < 200) begin
            @(negedge clk_i);
            if (drv_start_en) hi++;
            waited++;
        end
        check("timeout start cycles", 64'(hi), 64'(BUSY_TMO));
        check("timeout fail", 64'(cfg_fail), 64'(1));
        check("timeout start_en low", 64'(drv_start_en), 64'(0));
        check("timeout fail_index", 64'(fail_index), 64'(0));
        repeat (2) @(negedge clk_i);
        drv_mute = 1'b0;

        // Reset while waiting for the driver to finish, then a clean restart from index 0.
        clear_table();
        tbl[0] = 24'h111111;
        tbl[1] = 24'h222222;
        drv_hold_dur = 20;
        prep();
        pulse_start();
        waited = 0;
        while (!drv_busy && waited < 50) begin @(negedge clk_i); waited++; end
        check("reset test busy rise", 64'(drv_busy), 64'(1));
        repeat (3) @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        check("mid-transfer reset outputs", 64'({drv_start_en, tbl_addr, drv_register, drv_data_byte,
                                                 cfg_busy, cfg_done, cfg_fail, fail_index}), 64'(0));
        @(negedge clk_i);
        rst_n = 1'b1;
        pulse_start();
        @(negedge clk_i);
        check("start ignored while drv_busy", 64'({cfg_busy, drv_busy, drv_start_en}), 64'(3'b010));
        waited = 0;
        while (drv_busy && waited < 50) begin @(negedge clk_i); waited++; end
        drv_hold_dur = 0;
        run_cfg("restart");

        // No end marker anywhere: last slot completes, no wrap to index 0.
        clear_table();
        for (int j = 0; j < DEPTH; j++) tbl[j] = {16'(j * 3 + 1), 8'(j)};
        run_cfg("full table");
        check("full table count", 64'(att_log.size()), 64'(DEPTH));

        for (int r = 0; r < 10; r++) begin
            int n;
            clear_table();
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 4) == 0) tbl[j] = {16'hFFFE, 8'($urandom_range(0, 1))};
                else tbl[j] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
            end
            for (int k = 0; k < 256; k++) nack_seq[k] = ($urandom_range(0, 9) < 3);
            run_cfg($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
